leaf_stream_packetizer: RTL and testbench

Transmit-side endpoint that turns one 32-bit valid/ack word stream into 49-bit BFT packets addressed to a single input port of a remote leaf. It is the other end of a leaf's input port. It sits next to a leaf_interface inside a shell, or on the DMA side of the BFT root. Flow control is credit-based: credits are replenished by the free-space update packets that the destination leaf returns.

---
 rtl/bft_pkg.sv | 19 +
 rtl/stream_skid_buf.sv | 51 +++++
 rtl/leaf_stream_packetizer.sv | 173 +++++++++++++++++
 tb/tb_leaf_stream_packetizer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared BFT packet field layout, port ids and endpoint states.
// Field offsets assume the default 49-bit packet geometry.
package bft_pkg;

  localparam int ADDR_LSB = 32;
  localparam int PORT_LSB = 39;
  localparam int LEAF_LSB = 43;

  localparam int CFG_PORT    = 1;
  localparam int CREDIT_PORT = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CFG,
    S_RUN,
    S_STALL
  } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ack buffer with an empty-path bypass.
// Keeps the input handshake independent of output stalls.
module stream_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_push,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_pop
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             empty;
  logic             bypass;
  logic             store;
  logic             read;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign out_valid = !empty || in_push;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign bypass    = empty && out_pop;
  assign store     = in_push && !bypass;
  assign read      = out_pop && !empty;

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) wr_ptr <= ~wr_ptr;
      if (read)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, read};
    end
  end

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Stream-to-BFT packetizer for one remote leaf input port.
// Credit-based flow control fed by free-space update packets.
module leaf_stream_packetizer
  import bft_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_LEAF_BITS-1:0]      dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]      dst_port,
  input  logic [NUM_LEAF_BITS-1:0]      src_leaf,
  input  logic [NUM_PORT_BITS-1:0]      src_port,
  input  logic [PAYLOAD_BITS-1:0]       din,
  input  logic                          vld_in,
  output logic                          ack_out,
  input  logic [PACKET_BITS-1:0]        din_bft,
  output logic [PACKET_BITS-1:0]        dout_bft,
  input  logic                          resend,
  output logic [NUM_BRAM_ADDR_BITS:0]   credits
);

  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CW-1:0] MAX_CRED =
    {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
  localparam int PAD_ADDR = NUM_ADDR_BITS - NUM_PORT_BITS;
  localparam int PAD_PAY  =
    PAYLOAD_BITS - NUM_LEAF_BITS - NUM_PORT_BITS;

  state_t                     state;
  logic                       start_s1;
  logic                       start_s2;
  logic                       start_rise;
  logic [NUM_LEAF_BITS-1:0]   dst_leaf_q;
  logic [NUM_PORT_BITS-1:0]   dst_port_q;
  logic [NUM_ADDR_BITS-1:0]   seq;
  logic [CW-1:0]              cred_q;
  logic                       err_overflow;

  logic                       buf_full;
  logic                       buf_valid;
  logic [PAYLOAD_BITS-1:0]    buf_data;
  logic                       push;
  logic                       emit;

  logic                       credit_hit;
  logic                       bad_update;
  logic [CW-1:0]              credit_n;
  logic [CW+1:0]              cred_sum;
  logic                       cred_ovf;
  logic [CW-1:0]              cred_next;

  logic [PACKET_BITS-1:0]     cfg_pkt;
  logic [PACKET_BITS-1:0]     data_pkt;
  logic                       unused_bits;

  assign credits    = cred_q;
  assign ack_out    = !buf_full && (state == S_RUN);
  assign push       = vld_in && ack_out;
  assign emit       = (state == S_RUN) && !resend &&
                      (cred_q != '0) && buf_valid;
  assign start_rise = start_s1 && !start_s2;

  assign credit_hit =
    din_bft[PACKET_BITS-1] &&
    (din_bft[PORT_LSB +: NUM_PORT_BITS] ==
     NUM_PORT_BITS'(CREDIT_PORT)) &&
    (din_bft[LEAF_LSB +: NUM_LEAF_BITS] == dst_leaf_q);

  assign cfg_pkt = {
    1'b1,
    dst_leaf_q,
    NUM_PORT_BITS'(CFG_PORT),
    {{PAD_ADDR{1'b0}}, dst_port_q},
    {{PAD_PAY{1'b0}}, src_leaf, src_port}
  };

  assign data_pkt = {1'b1, dst_leaf_q, dst_port_q, seq, buf_data};

  assign unused_bits =
    ^{din_bft[PORT_LSB-1:NUM_BRAM_ADDR_BITS+1], err_overflow};

  stream_skid_buf #(
    .WIDTH(PAYLOAD_BITS)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (din),
    .in_push  (push),
    .full     (buf_full),
    .out_data (buf_data),
    .out_valid(buf_valid),
    .out_pop  (emit)
  );

  // Credit return and word emission fold into one saturating update.
  always_comb begin
    credit_n   = '0;
    if (credit_hit) credit_n = din_bft[NUM_BRAM_ADDR_BITS:0];
    bad_update = credit_hit &&
                 (int'(credit_n) > FREESPACE_UPDATE_SIZE);
    cred_sum   = {2'b00, cred_q} + {2'b00, credit_n} -
                 {{(CW+1){1'b0}}, emit};
    cred_ovf   = cred_sum > {2'b00, MAX_CRED};
    cred_next  = cred_ovf ? MAX_CRED : cred_sum[CW-1:0];
  end

  // Start level is registered twice to find its rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
    end
  end

  // Credit counter with sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cred_q       <= MAX_CRED;
      err_overflow <= 1'b0;
    end else begin
      cred_q <= cred_next;
      if (cred_ovf || bad_update) err_overflow <= 1'b1;
    end
  end

  // Endpoint FSM with registered packet output held under resend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dout_bft   <= '0;
      seq        <= '0;
      dst_leaf_q <= '0;
      dst_port_q <= '0;
    end else begin
      if (!resend) begin
        if (emit)                 dout_bft <= data_pkt;
        else if (state == S_CFG)  dout_bft <= cfg_pkt;
        else                      dout_bft <= '0;
      end
      unique case (state)
        S_IDLE: begin
          if (start_rise) begin
            dst_leaf_q <= dst_leaf;
            dst_port_q <= dst_port;
            state      <= S_CFG;
          end
        end
        S_CFG: begin
          if (!resend) state <= S_RUN;
        end
        S_RUN: begin
          if (emit) seq <= seq + 1'b1;
          if (cred_next == '0) state <= S_STALL;
        end
        S_STALL: begin
          if (cred_q != '0) state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Randomized scoreboard bench for leaf_stream_packetizer.
// Expected packets are queued at acceptance, popped at output.
module tb_leaf_stream_packetizer;
  import bft_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  dst_leaf = '0;
  logic [3:0]  dst_port = '0;
  logic [4:0]  src_leaf = '0;
  logic [3:0]  src_port = '0;
  logic [31:0] din = '0;
  logic        vld_in = 1'b0;
  logic        ack_out;
  logic [48:0] din_bft = '0;
  logic [48:0] dout_bft;
  logic        resend = 1'b0;
  logic [7:0]  credits;

  always #5 clk = ~clk;

  leaf_stream_packetizer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .dst_leaf(dst_leaf),
    .dst_port(dst_port),
    .src_leaf(src_leaf),
    .src_port(src_port),
    .din     (din),
    .vld_in  (vld_in),
    .ack_out (ack_out),
    .din_bft (din_bft),
    .dout_bft(dout_bft),
    .resend  (resend),
    .credits (credits)
  );

  typedef struct {
    logic [48:0] pkt;
    bit          is_data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          pkt_cnt = 0;
  int          cred_model = 128;
  int          seq_model = 0;
  int          n_acc = 0;
  bit          rs_q = 1'b0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_d = '0;
  logic [4:0]  m_leaf = '0;
  logic [3:0]  m_port = '0;

  function automatic exp_t mk(input logic [48:0] p, input bit d);
    exp_t e;
    e.pkt = p;
    e.is_data = d;
    return e;
  endfunction

  function automatic logic [48:0] cfg_exp(
    input logic [4:0] dl, input logic [3:0] dp,
    input logic [4:0] sl, input logic [3:0] sp);
    logic [6:0]  a;
    logic [31:0] pay;
    a = 7'(dp);
    pay = 32'(sl) * 32'd16 + 32'(sp);
    return {1'b1, dl, 4'd1, a, pay};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rs_q <= resend;

  // A packet is new when it was not held by resend at the last edge.
  always @(negedge clk) begin
    if (reset_n && dout_bft[48] && !rs_q) begin
      pkt_cnt++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pkt: got %h want none", dout_bft);
      end else begin
        mon_e = sbq.pop_front();
        if (dout_bft !== mon_e.pkt) begin
          bad++;
          $display("FAIL pkt: got %h want %h", dout_bft, mon_e.pkt);
        end
        if (mon_e.is_data) cred_model--;
      end
    end
  end

  // One clock of stimulus, entered and left at negedge+1.
  // pv: 0 = no new word, 1 = random word, 2 = force a word.
  task automatic cyc(input int pv, input bit rs,
                     input logic [48:0] bft, output bit acc);
    logic [6:0] sq;
    int n;
    if (!pend_v && (pv == 2 ||
        (pv == 1 && $urandom_range(3, 0) != 0))) begin
      pend_v = 1'b1;
      pend_d = $urandom;
    end
    vld_in  = pend_v;
    din     = pend_d;
    resend  = rs;
    din_bft = bft;
    #1;
    acc = vld_in && ack_out;
    if (acc) begin
      sq = 7'(seq_model);
      sbq.push_back(mk({1'b1, m_leaf, m_port, sq, pend_d}, 1'b1));
      seq_model = (seq_model + 1) % 128;
      pend_v = 1'b0;
      n_acc++;
    end
    if (bft[48] && bft[42:39] == 4'd0 && bft[47:43] == m_leaf) begin
      n = cred_model + int'(bft[7:0]);
      cred_model = (n > 128) ? 128 : n;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit          acc;
    int          c0;
    int          guard;
    logic [48:0] hold;
    logic [48:0] cp;
    logic [48:0] ign [3];

    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout", dout_bft, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_cred", credits, 128);
    chk("rst_state", dut.state, S_IDLE);
    reset_n = 1'b1;
    @(negedge clk);
    #1;

    m_leaf = 5'd3;
    m_port = 4'd2;
    dst_leaf = 5'd3;
    dst_port = 4'd2;
    src_leaf = 5'd1;
    src_port = 4'd4;
    sbq.push_back(mk(cfg_exp(5'd3, 4'd2, 5'd1, 4'd4), 1'b0));
    start = 1'b1;
    cyc(0, 0, '0, acc);
    cyc(0, 0, '0, acc);
    chk("cfg_early", pkt_cnt, 0);
    cyc(0, 0, '0, acc);
    chk("cfg_latency", pkt_cnt, 1);
    start = 1'b0;
    dst_leaf = 5'd9;
    dst_port = 4'd12;

    n_acc = 0;
    guard = 0;
    while (n_acc < 128 && guard < 2000) begin
      cyc(1, 0, '0, acc);
      guard++;
    end
    chk("stream_cnt", n_acc, 128);
    cyc(2, 0, '0, acc);
    chk("stall_ack", acc, 0);
    chk("stall_cred", credits, 0);
    chk("stall_state", dut.state, S_STALL);
    c0 = pkt_cnt;
    cyc(2, 0, '0, acc);
    chk("stall_quiet", pkt_cnt, c0);

    cp = {1'b1, 5'd3, 4'd0, 7'd0, 32'd64};
    cyc(2, 0, cp, acc);
    chk("cred_ret", credits, 64);
    cyc(2, 0, '0, acc);
    chk("resume_early", pkt_cnt, c0);
    cyc(2, 0, '0, acc);
    chk("resume_t2", pkt_cnt, c0 + 1);

    guard = 0;
    while (cred_model != 10 && guard < 2000) begin
      cyc(1, 0, '0, acc);
      guard++;
    end
    chk("cred_ten", credits, 10);
    cyc(2, 0, cp, acc);
    chk("merge_acc", acc, 1);
    chk("merge_cred", credits, 73);

    cyc(2, 0, '0, acc);
    hold = dout_bft;
    chk("pre_hold_vld", hold[48], 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, '0, acc);
      chk("resend_hold", dout_bft, hold);
    end
    chk("resend_cred", credits, cred_model);
    repeat (6) cyc(0, 0, '0, acc);
    chk("resend_drain", sbq.size(), 0);

    n_acc = 0;
    guard = 0;
    while (n_acc < 20 && cred_model > 50 && guard < 2000) begin
      cyc(1, ($urandom_range(4, 0) == 0), '0, acc);
      guard++;
    end
    repeat (6) cyc(0, 0, '0, acc);
    chk("rnd_cred", credits, cred_model);
    chk("rnd_drain", sbq.size(), 0);

    guard = 0;
    while (cred_model > 41 && guard < 2000) begin
      cyc(1, 0, '0, acc);
      guard++;
    end
    cyc(2, 0, '0, acc);
    chk("pre_rst_cred", credits, 40);
    chk("pre_rst_vld", dout_bft[48], 1);

    reset_n = 1'b0;
    #1;
    chk("arst_dout", dout_bft, 0);
    chk("arst_ack", ack_out, 0);
    chk("arst_cred", credits, 128);
    sbq.delete();
    cred_model = 128;
    seq_model = 0;
    m_leaf = '0;
    m_port = '0;
    pend_v = 1'b0;
    vld_in = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    c0 = pkt_cnt;
    repeat (10) cyc(1, 0, '0, acc);
    chk("post_rst_quiet", pkt_cnt, c0);
    chk("post_rst_state", dut.state, S_IDLE);
    chk("post_rst_cred", credits, 128);
    chk("post_rst_ack", ack_out, 0);

    m_leaf = 5'd5;
    m_port = 4'd7;
    dst_leaf = 5'd5;
    dst_port = 4'd7;
    src_leaf = 5'd2;
    src_port = 4'd9;
    sbq.push_back(mk(cfg_exp(5'd5, 4'd7, 5'd2, 4'd9), 1'b0));
    start = 1'b1;
    repeat (3) cyc(0, 0, '0, acc);
    n_acc = 0;
    guard = 0;
    while (n_acc < 10 && guard < 2000) begin
      cyc(1, 0, '0, acc);
      guard++;
    end
    repeat (3) cyc(0, 0, '0, acc);
    chk("run2_cred", credits, cred_model);

    cp = {1'b1, 5'd5, 4'd0, 7'd0, 32'd100};
    cyc(0, 0, cp, acc);
    chk("cred_sat", credits, 128);

    n_acc = 0;
    guard = 0;
    while (n_acc < 3 && guard < 2000) begin
      cyc(1, 0, '0, acc);
      guard++;
    end
    repeat (3) cyc(0, 0, '0, acc);
    ign[0] = {1'b1, 5'd6, 4'd0, 7'd0, 32'd50};
    ign[1] = {1'b1, 5'd5, 4'd3, 7'd0, 32'd50};
    ign[2] = {1'b0, 5'd5, 4'd0, 7'd0, 32'd50};
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, ign[i], acc);
      chk("cred_ignore", credits, 125);
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      cyc(0, 0, '0, acc);
      guard++;
    end
    chk("final_drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
